alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command-side initiator for the team's 4-bit combinational ALU.
- Accepts instruction words over a valid/ready channel and reads operands from a 4-entry x 4-bit register file.
- Drives the ALU operand and select lines, captures the result and flags, writes back, and returns a response over a second valid/ready channel.
- Sits between the instruction source (testbench or fetch unit) and the ALU.

Parameters:
NREGS, 4, register-file depth; must be 4, because the instruction encodes a 2-bit register index.
DW, 4, data width; fixed at 4 to match the ALU.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  instruction presented
cmd_ready  out  1  sequencer can accept an instruction
cmd_instr  in  10  {op[9:6], rd[5:4], rs1[3:2], rs2[1:0]}
alu_a  out  4  ALU operand A = rf[rs1]
alu_b  out  4  ALU operand B = rf[rs2]
alu_sel  out  4  ALU select = op
alu_out  in  4  ALU result
alu_carry  in  1  ALU carry/borrow-out
alu_zero  in  1  ALU zero flag
alu_neg  in  1  ALU negative flag (result bit 3)
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  4  value written to rd (0 on error)
rsp_flags  out  3  {C, Z, N} architectural flags after this instruction
rsp_err  out  1  illegal opcode; no writeback performed

Behaviour:
Legal opcodes:
- ALU ops: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- LDI 1111: rd <= {rs1,rs2}; the ALU is not used.
- Any other opcode is illegal.

FSM states and transitions:
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_instr and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_a, alu_b and alu_sel are driven combinationally from the latched instruction and the current rf.
  - On the exit edge: sample alu_out and flags, perform writeback, update the flag register, load the rsp_* registers, go to RESP.
- RESP: rsp_valid=1 and rsp_* held stable. On rsp_ready, go to IDLE.

Latency and throughput:
- Accept at edge N gives rsp_valid high from N+1 to N+2, i.e. 2 cycles.
- Peak throughput is 1 instruction per 3 cycles.
- cmd_ready=0 in ISSUE and RESP.

Outputs outside ISSUE:
- alu_a, alu_b and alu_sel are 0 in IDLE and RESP.

Flag register {C,Z,N}:
- C updates only on ADD/SUB. It takes alu_carry, which is the raw 5th bit of the 4-bit add/subtract; for SUB, C=1 means borrow.
- Z and N update on every ALU op.
- For LDI: Z=(imm==0), N=imm[3], C unchanged.
- An illegal op leaves flags and rf unchanged. It still returns a response, with rsp_err=1, rsp_data=0, and rsp_flags = current flags.

Hazards and boundaries:
- rd equal to rs1/rs2: the operand is the old value; the write lands on the ISSUE exit edge.
- The next instruction always sees the written value; there is no forwarding requirement.
- rsp_ready may be held high continuously; the sequencer returns to IDLE the cycle after RESP is entered.
- cmd_valid while busy is ignored. The source must hold the instruction until cmd_ready.

Reset (async, mid-operation included):
- State returns to IDLE; any in-flight instruction is discarded and no response is produced.
- rf[0..3], flags and the latched instruction reset to 0.
- cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0.
- alu_a, alu_b and alu_sel read 0.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined: adds output perf_retired[7:0]. It increments on each RESP handshake where rsp_err=0, saturates at 255, and resets to 0.
- Also adds output perf_err[3:0], an illegal-op count that saturates at 15.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
Shared package alu_seq_pkg holds:
- The opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_LDI.
- The state encoding: S_IDLE, S_ISSUE, S_RESP.
- The instruction field bit positions.
- An is_legal_op function.

One sub-module is natural: alu_seq_regfile.
- 4x4 registers, two combinational read ports, one write port.
- Asynchronous active-low clear.

The ALU itself stays external.

Test Plan:
1. Reset, then LDI r1=0x9 and LDI r2=0x3 -> responses data 9 flags{C0,Z0,N1} and data 3 flags{0,0,0}. Check rsp_valid exactly 2 cycles after each accept.
2. ADD r3=r1+r2 with r1=0x9, r2=0x9 -> alu_sel=0010, alu_a=9, alu_b=9 seen in ISSUE; rsp_data=0x2, flags{C1,Z0,N0}; r3 reads 2 on the next op.
3. SUB r0=r2-r2 with r2=3 -> data 0, Z=1, C=0. Then AND r0=r1&r2 -> C stays at its SUB value and only Z/N update.
4. Opcode 0101 -> rsp_err=1, rsp_data=0, flags and rf unchanged (verify with an OR readback). With ALU_SEQ_PERF_EN: perf_err=1, perf_retired not incremented.
5. Backpressure: hold rsp_ready=0 for 5 cycles in RESP while cmd_valid=1 -> cmd_ready stays 0 and rsp_* are stable. rsp_ready=1 -> IDLE next cycle, then the new instruction is accepted.
6. Assert rst_n=0 during ISSUE of ADD r1 -> no response; all outputs and rf are 0. After release, NOR r0=r0|r0 -> data 0xF, N=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// instruction field positions and opcode legality helper.
package alu_seq_pkg;

  localparam int DW    = 4;
  localparam int NREGS = 4;
  localparam int AW    = $clog2(NREGS);
  localparam int IW    = 10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_LDI = 4'b1111;

  // Instruction layout {op, rd, rs1, rs2}; LDI reuses {rs1, rs2} as its immediate.
  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_LDI: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signals of the sequencer. The master modport is
// the environment (instruction source, response consumer and ALU); slave is the sequencer.
interface alu_cmd_sequencer_if;
  import alu_seq_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_instr;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_carry;
  logic          alu_zero;
  logic          alu_neg;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [2:0]    rsp_flags;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_instr, rsp_ready, alu_out, alu_carry, alu_zero, alu_neg,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_instr, rsp_ready, alu_out, alu_carry, alu_zero, alu_neg,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// 4 x 4-bit register file with two combinational read ports, one write port
// and an asynchronous active-low clear.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads are combinational, so an operand equal to rd returns the pre-write value.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Single-issue command sequencer for the external 4-bit ALU: IDLE -> ISSUE -> RESP.
// Define ALU_SEQ_PERF_EN to add saturating perf_retired / perf_err counters.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave io
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [7:0]         perf_retired,
  output logic [3:0]         perf_err
`endif
);

  state_t        state;
  logic [IW-1:0] instr_q;
  logic [2:0]    flags_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [DW-1:0] rsp_data_q;
  logic [2:0]    rsp_flags_q;

  logic [3:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [DW-1:0] imm;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic [DW-1:0] wr_data;
  logic [2:0]    next_flags;
  logic          issue;
  logic          legal;
  logic          wr_en;

  assign op    = instr_q[OP_MSB:OP_LSB];
  assign rd    = instr_q[RD_MSB:RD_LSB];
  assign rs1   = instr_q[RS1_MSB:RS1_LSB];
  assign rs2   = instr_q[RS2_MSB:RS2_LSB];
  assign imm   = {rs1, rs2};
  assign issue = (state == S_ISSUE);
  assign legal = is_legal_op(op);
  assign wr_en = issue && legal;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (rd),
    .wdata   (wr_data),
    .raddr_a (rs1),
    .rdata_a (rf_a),
    .raddr_b (rs2),
    .rdata_b (rf_b)
  );

  // The ALU bus carries operands only during ISSUE and is parked at zero otherwise.
  assign io.alu_a   = issue ? rf_a : '0;
  assign io.alu_b   = issue ? rf_b : '0;
  assign io.alu_sel = issue ? op   : '0;

  // C follows the raw adder carry on ADD/SUB only; LDI sets Z/N from its immediate.
  always_comb begin
    wr_data    = '0;
    next_flags = flags_q;
    if (op == OP_LDI) begin
      wr_data            = imm;
      next_flags[FLAG_Z] = (imm == '0);
      next_flags[FLAG_N] = imm[DW-1];
    end else if (legal) begin
      wr_data            = io.alu_out;
      next_flags[FLAG_Z] = io.alu_zero;
      next_flags[FLAG_N] = io.alu_neg;
      if (op == OP_ADD || op == OP_SUB) next_flags[FLAG_C] = io.alu_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      flags_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.cmd_valid) begin
            instr_q     <= io.cmd_instr;
            cmd_ready_q <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          flags_q     <= next_flags;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= wr_data;
          rsp_flags_q <= next_flags;
          rsp_err_q   <= !legal;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (io.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign io.cmd_ready = cmd_ready_q;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_data  = rsp_data_q;
  assign io.rsp_flags = rsp_flags_q;
  assign io.rsp_err   = rsp_err_q;

`ifdef ALU_SEQ_PERF_EN
  // Both counters advance on the response handshake so a discarded instruction never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_err     <= '0;
    end else if (state == S_RESP && io.rsp_ready) begin
      if (!rsp_err_q) begin
        if (perf_retired != 8'hFF) perf_retired <= perf_retired + 8'd1;
      end else begin
        if (perf_err != 4'hF) perf_err <= perf_err + 4'd1;
      end
    end
  end
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed vector table, multi-cycle
// corner sequences and randomized instructions against a behavioural model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus ();

`ifdef ALU_SEQ_PERF_EN
  logic [7:0] perf_retired;
  logic [3:0] perf_err;
`endif

  alu_cmd_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io           (bus)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_err     (perf_err)
`endif
  );

  // Stand-in for the team ALU; SLT compares operands as signed 4-bit values.
  logic [4:0] alu_wide;
  always_comb begin
    alu_wide = 5'd0;
    case (bus.alu_sel)
      4'b0000: alu_wide = {1'b0, bus.alu_a & bus.alu_b};
      4'b0001: alu_wide = {1'b0, bus.alu_a | bus.alu_b};
      4'b0010: alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'b0110: alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      4'b0111: alu_wide = {4'b0000, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      4'b1100: alu_wide = {1'b0, ~(bus.alu_a | bus.alu_b)};
      default: alu_wide = 5'd0;
    endcase
  end
  assign bus.alu_out   = alu_wide[3:0];
  assign bus.alu_carry = alu_wide[4];
  assign bus.alu_zero  = (alu_wide[3:0] == 4'd0);
  assign bus.alu_neg   = alu_wide[3];

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] rf_m [4];
  logic [2:0] flags_m;
  int         ret_m;
  int         err_m;

  logic       obs_timeout;
  logic       obs_issue_valid;
  logic       obs_issue_ready;
  logic [3:0] obs_a;
  logic [3:0] obs_b;
  logic [3:0] obs_sel;
  logic       obs_resp_valid;
  logic [3:0] obs_data;
  logic [2:0] obs_flags;
  logic       obs_err;
  logic [3:0] obs_resp_alu;
  logic       obs_idle_ready;
  logic       obs_idle_valid;

  typedef struct {
    logic [9:0] instr;
    logic [3:0] data;
    logic [2:0] flags;
    logic       err;
  } vec_t;

  vec_t       vecs [14];
  logic [3:0] legal_ops [7];

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sx4(input int x);
    return (x > 7) ? x - 16 : x;
  endfunction

  // Architectural model: operands, result, flags and register file as plain integers.
  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
    flags_m = 3'b000;
    ret_m   = 0;
    err_m   = 0;
  endtask

  task automatic model_exec(input logic [9:0] instr, output logic [3:0] d,
                            output logic [2:0] f, output logic e);
    int   a;
    int   b;
    int   r;
    logic c;
    a = rf_m[instr[3:2]];
    b = rf_m[instr[1:0]];
    r = 0;
    c = flags_m[2];
    e = 1'b0;
    case (instr[9:6])
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; c = (r > 15); end
      4'b0110: begin r = a - b; c = (a < b); end
      4'b0111: r = (sx4(a) < sx4(b)) ? 1 : 0;
      4'b1100: r = 15 - (a | b);
      4'b1111: r = int'(instr[3:0]);
      default: e = 1'b1;
    endcase
    if (e) begin
      d = 4'd0;
      f = flags_m;
      if (err_m < 15) err_m++;
    end else begin
      r = r & 15;
      d = 4'(r);
      f = {c, (r == 0), (r >= 8)};
      flags_m = f;
      rf_m[instr[5:4]] = d;
      if (ret_m < 255) ret_m++;
    end
  endtask

  // Called #1 after a rising edge with rsp_ready high; walks one instruction through all states.
  task automatic apply_stimulus(input logic [9:0] instr);
    logic rdy;
    obs_timeout   = 1'b1;
    bus.cmd_instr = instr;
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin
        obs_timeout = 1'b0;
        break;
      end
    end
    bus.cmd_valid   = 1'b0;
    obs_issue_valid = bus.rsp_valid;
    obs_issue_ready = bus.cmd_ready;
    obs_a           = bus.alu_a;
    obs_b           = bus.alu_b;
    obs_sel         = bus.alu_sel;
    @(posedge clk); #1;
    obs_resp_valid  = bus.rsp_valid;
    obs_data        = bus.rsp_data;
    obs_flags       = bus.rsp_flags;
    obs_err         = bus.rsp_err;
    obs_resp_alu    = bus.alu_a | bus.alu_b | bus.alu_sel;
    @(posedge clk); #1;
    obs_idle_ready  = bus.cmd_ready;
    obs_idle_valid  = bus.rsp_valid;
  endtask

  task automatic check_output(input string tag, input logic [3:0] ed, input logic [2:0] ef,
                              input logic ee, input logic [3:0] ea, input logic [3:0] eb,
                              input logic [3:0] esel);
    compare({tag, " accept_timeout"}, 8'(obs_timeout), 8'd0);
    compare({tag, " issue_rsp_valid"}, 8'(obs_issue_valid), 8'd0);
    compare({tag, " issue_cmd_ready"}, 8'(obs_issue_ready), 8'd0);
    compare({tag, " alu_a"}, 8'(obs_a), 8'(ea));
    compare({tag, " alu_b"}, 8'(obs_b), 8'(eb));
    compare({tag, " alu_sel"}, 8'(obs_sel), 8'(esel));
    compare({tag, " rsp_valid"}, 8'(obs_resp_valid), 8'd1);
    compare({tag, " rsp_data"}, 8'(obs_data), 8'(ed));
    compare({tag, " rsp_flags"}, 8'(obs_flags), 8'(ef));
    compare({tag, " rsp_err"}, 8'(obs_err), 8'(ee));
    compare({tag, " resp_alu_bus"}, 8'(obs_resp_alu), 8'd0);
    compare({tag, " idle_cmd_ready"}, 8'(obs_idle_ready), 8'd1);
    compare({tag, " idle_rsp_valid"}, 8'(obs_idle_valid), 8'd0);
`ifdef ALU_SEQ_PERF_EN
    compare({tag, " perf_retired"}, perf_retired, 8'(ret_m));
    compare({tag, " perf_err"}, 8'(perf_err), 8'(err_m));
`endif
  endtask

  task automatic run_model_txn(input string tag, input logic [9:0] instr);
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] d;
    logic [2:0] f;
    logic       e;
    ea = rf_m[instr[3:2]];
    eb = rf_m[instr[1:0]];
    model_exec(instr, d, f, e);
    apply_stimulus(instr);
    check_output(tag, d, f, e, ea, eb, instr[9:6]);
  endtask

  task automatic check_reset_outputs(input string tag);
    compare({tag, " cmd_ready"}, 8'(bus.cmd_ready), 8'd1);
    compare({tag, " rsp_valid"}, 8'(bus.rsp_valid), 8'd0);
    compare({tag, " rsp_data"}, 8'(bus.rsp_data), 8'd0);
    compare({tag, " rsp_flags"}, 8'(bus.rsp_flags), 8'd0);
    compare({tag, " rsp_err"}, 8'(bus.rsp_err), 8'd0);
    compare({tag, " alu_bus"}, 8'(bus.alu_a | bus.alu_b | bus.alu_sel), 8'd0);
`ifdef ALU_SEQ_PERF_EN
    compare({tag, " perf_retired"}, perf_retired, 8'd0);
    compare({tag, " perf_err"}, 8'(perf_err), 8'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] d;
    logic [2:0] f;
    logic [3:0] bp_data;
    logic [2:0] bp_flags;
    logic       e;
    logic [3:0] op;
    logic [9:0] instr;

    vecs[0]  = '{10'b1111_01_10_01, 4'h9, 3'b001, 1'b0};
    vecs[1]  = '{10'b1111_10_00_11, 4'h3, 3'b000, 1'b0};
    vecs[2]  = '{10'b1111_10_10_01, 4'h9, 3'b001, 1'b0};
    vecs[3]  = '{10'b0010_11_01_10, 4'h2, 3'b100, 1'b0};
    vecs[4]  = '{10'b0001_00_11_11, 4'h2, 3'b100, 1'b0};
    vecs[5]  = '{10'b1111_10_00_11, 4'h3, 3'b100, 1'b0};
    vecs[6]  = '{10'b0110_00_10_10, 4'h0, 3'b010, 1'b0};
    vecs[7]  = '{10'b0000_00_01_10, 4'h1, 3'b000, 1'b0};
    vecs[8]  = '{10'b0101_00_00_00, 4'h0, 3'b000, 1'b1};
    vecs[9]  = '{10'b0001_10_00_00, 4'h1, 3'b000, 1'b0};
    vecs[10] = '{10'b0111_11_01_10, 4'h1, 3'b000, 1'b0};
    vecs[11] = '{10'b1100_00_01_10, 4'h6, 3'b000, 1'b0};
    vecs[12] = '{10'b0110_11_10_01, 4'h8, 3'b101, 1'b0};
    vecs[13] = '{10'b1111_00_00_00, 4'h0, 3'b110, 1'b0};

    legal_ops[0] = OP_AND;
    legal_ops[1] = OP_OR;
    legal_ops[2] = OP_ADD;
    legal_ops[3] = OP_SUB;
    legal_ops[4] = OP_SLT;
    legal_ops[5] = OP_NOR;
    legal_ops[6] = OP_LDI;

    bus.cmd_valid = 1'b0;
    bus.cmd_instr = 10'd0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    model_reset();

    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      ea = rf_m[vecs[i].instr[3:2]];
      eb = rf_m[vecs[i].instr[1:0]];
      model_exec(vecs[i].instr, d, f, e);
      apply_stimulus(vecs[i].instr);
      check_output($sformatf("vec%0d", i), vecs[i].data, vecs[i].flags, vecs[i].err,
                   ea, eb, vecs[i].instr[9:6]);
    end

    $display("[TB] backpressure with cmd_valid held while busy");
    bus.rsp_ready = 1'b0;
    bus.cmd_instr = 10'b1111_11_01_01;
    bus.cmd_valid = 1'b1;
    compare("bp idle_cmd_ready", 8'(bus.cmd_ready), 8'd1);
    @(posedge clk); #1;
    bus.cmd_instr = 10'b0001_00_11_11;
    compare("bp issue_cmd_ready", 8'(bus.cmd_ready), 8'd0);
    @(posedge clk); #1;
    model_exec(10'b1111_11_01_01, bp_data, bp_flags, e);
    for (int i = 0; i < 5; i++) begin
      compare($sformatf("bp hold%0d cmd_ready", i), 8'(bus.cmd_ready), 8'd0);
      compare($sformatf("bp hold%0d rsp_valid", i), 8'(bus.rsp_valid), 8'd1);
      compare($sformatf("bp hold%0d rsp_data", i), 8'(bus.rsp_data), 8'(bp_data));
      compare($sformatf("bp hold%0d rsp_flags", i), 8'(bus.rsp_flags), 8'(bp_flags));
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    compare("bp release cmd_ready", 8'(bus.cmd_ready), 8'd1);
    compare("bp release rsp_valid", 8'(bus.rsp_valid), 8'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    compare("bp second accept cmd_ready", 8'(bus.cmd_ready), 8'd0);
    compare("bp second alu_sel", 8'(bus.alu_sel), 8'(OP_OR));
    compare("bp second alu_a", 8'(bus.alu_a), 8'(rf_m[3]));
    model_exec(10'b0001_00_11_11, d, f, e);
    @(posedge clk); #1;
    compare("bp second rsp_valid", 8'(bus.rsp_valid), 8'd1);
    compare("bp second rsp_data", 8'(bus.rsp_data), 8'(d));
    compare("bp second rsp_flags", 8'(bus.rsp_flags), 8'(f));
    @(posedge clk); #1;

    $display("[TB] reset during ISSUE");
    bus.cmd_instr = 10'b0010_01_01_10;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    compare("rst_mid issue alu_sel", 8'(bus.alu_sel), 8'(OP_ADD));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    compare("rst_mid no_response", 8'(bus.rsp_valid), 8'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    compare("rst_mid post cmd_ready", 8'(bus.cmd_ready), 8'd1);
    model_reset();
    apply_stimulus(10'b1100_00_00_00);
    model_exec(10'b1100_00_00_00, d, f, e);
    check_output("rst_nor", 4'hF, 3'b001, 1'b0, 4'h0, 4'h0, OP_NOR);
    run_model_txn("rst_readback", 10'b0001_01_10_11);

    $display("[TB] randomized instructions");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom);
      else op = legal_ops[$urandom_range(0, 6)];
      instr = {op, 6'($urandom)};
      run_model_txn($sformatf("rand%0d instr=0x%0h", i, instr), instr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
